// File: rtl/cv32e40p_tmr_vote_monitor_if.sv
// Bundle of replica data, vote results, health control and event statistics
// for the TMR vote monitor. Master drives replica data and control; slave votes.
interface cv32e40p_tmr_vote_monitor_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EVT_W  = 16
);
  logic [2:0][DATA_W-1:0] to_vote_i;
  logic [2:0][DATA_W-1:0] voted_o;
  logic [2:0]             block_err_o;
  logic                   err_detected_o;
  logic                   err_corrected_o;
  logic                   uncorrectable_o;
  logic [2:0]             set_broken_i;
  logic [2:0]             clear_broken_i;
  logic [2:0]             is_broken_o;
  logic                   all_broken_o;
  logic                   cnt_clear_i;
  logic [EVT_W-1:0]       corr_cnt_o;
  logic [EVT_W-1:0]       uncorr_cnt_o;

  modport master (
    output to_vote_i, set_broken_i, clear_broken_i, cnt_clear_i,
    input  voted_o, block_err_o, err_detected_o, err_corrected_o, uncorrectable_o,
    input  is_broken_o, all_broken_o, corr_cnt_o, uncorr_cnt_o
  );

  modport slave (
    input  to_vote_i, set_broken_i, clear_broken_i, cnt_clear_i,
    output voted_o, block_err_o, err_detected_o, err_corrected_o, uncorrectable_o,
    output is_broken_o, all_broken_o, corr_cnt_o, uncorr_cnt_o
  );
endinterface

// File: rtl/cv32e40p_tmr_vote_monitor.sv
// TMR voter with per-replica fault attribution, leaky health counters,
// sticky breakage flags with software repair, and saturating event counters.
module cv32e40p_tmr_vote_monitor #(
  parameter int unsigned DATA_W             = 32,
  parameter int unsigned TOUT               = 1,
  parameter int unsigned PIPE               = 0,
  parameter int unsigned COUNT_BIT          = 4,
  parameter int unsigned INCREMENT          = 2,
  parameter int unsigned DECREMENT          = 1,
  parameter int unsigned BREAKING_THRESHOLD = 8,
  parameter int unsigned EVT_W              = 16
) (
  input logic                         clk,
  input logic                         rst,
  cv32e40p_tmr_vote_monitor_if.slave  bus
);

  localparam int unsigned CntMax = (1 << COUNT_BIT) - 1;

  logic [2:0]             healthy;
  logic [2:0][DATA_W-1:0] voted_d;
  logic [2:0]             block_err_d;
  logic                   err_detected_d;
  logic                   err_corrected_d;
  logic                   uncorrectable_d;

  logic [COUNT_BIT-1:0]   cnt_q [3];
  logic [COUNT_BIT-1:0]   cnt_d [3];
  logic [2:0]             broken_q, broken_d;
  logic [EVT_W-1:0]       corr_cnt_q, corr_cnt_d;
  logic [EVT_W-1:0]       uncorr_cnt_q, uncorr_cnt_d;

  assign healthy = ~broken_q;

  // Broken replicas are skipped; with no majority the lowest healthy index wins.
  function automatic logic [DATA_W-1:0] vote_fn(input logic [2:0][DATA_W-1:0] v,
                                                input logic [2:0]             h);
    if (h == 3'b111) begin
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    end else if (h[0] || (h == 3'b000)) begin
      return v[0];
    end else if (h[1]) begin
      return v[1];
    end else begin
      return v[2];
    end
  endfunction

  // Voter redundancy: one voter per lane, or a single voter fanned out.
  if (TOUT != 0) begin : g_tout
    for (genvar l = 0; l < 3; l++) begin : g_lane
      assign voted_d[l] = vote_fn(bus.to_vote_i, healthy);
    end
  end else begin : g_single
    logic [DATA_W-1:0] vote_single;
    assign vote_single = vote_fn(bus.to_vote_i, healthy);
    assign voted_d     = {3{vote_single}};
  end

  // Error classification depends on how many replicas are still trusted.
  always_comb begin
    block_err_d     = '0;
    err_detected_d  = 1'b0;
    err_corrected_d = 1'b0;
    uncorrectable_d = 1'b0;
    case (healthy)
      3'b111: begin
        for (int r = 0; r < 3; r++) begin
          block_err_d[r] = (bus.to_vote_i[r] != voted_d[0]);
        end
        err_detected_d  = |block_err_d;
        err_corrected_d = |block_err_d;
      end
      // Two survivors that disagree cannot be arbitrated or attributed.
      3'b011: err_detected_d = (bus.to_vote_i[0] != bus.to_vote_i[1]);
      3'b101: err_detected_d = (bus.to_vote_i[0] != bus.to_vote_i[2]);
      3'b110: err_detected_d = (bus.to_vote_i[1] != bus.to_vote_i[2]);
      default: ;
    endcase
    if (healthy != 3'b111) begin
      uncorrectable_d = err_detected_d;
    end
  end

  // Health counters and sticky breakage flags.
  always_comb begin
    int unsigned sum;
    sum      = 0;
    broken_d = broken_q;
    for (int r = 0; r < 3; r++) begin
      cnt_d[r] = cnt_q[r];
      if (bus.clear_broken_i[r]) begin
        cnt_d[r] = '0;
      end else if (broken_q[r]) begin
        cnt_d[r] = cnt_q[r];
      end else if (block_err_d[r]) begin
        sum      = 32'(cnt_q[r]) + INCREMENT;
        cnt_d[r] = (sum > CntMax) ? COUNT_BIT'(CntMax) : COUNT_BIT'(sum);
      end else begin
        cnt_d[r] = (32'(cnt_q[r]) < DECREMENT) ? '0 : COUNT_BIT'(32'(cnt_q[r]) - DECREMENT);
      end

      // Forced breakage outranks repair; the counter still clears above.
      if (bus.set_broken_i[r]) begin
        broken_d[r] = 1'b1;
      end else if (bus.clear_broken_i[r]) begin
        broken_d[r] = 1'b0;
      end else if (32'(cnt_d[r]) >= BREAKING_THRESHOLD) begin
        broken_d[r] = 1'b1;
      end
    end
  end

  // Saturating event counters; clear outranks increment.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (bus.cnt_clear_i) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else begin
      if (err_corrected_d && (corr_cnt_q != '1)) begin
        corr_cnt_d = corr_cnt_q + 1'b1;
      end
      if (uncorrectable_d && (uncorr_cnt_q != '1)) begin
        uncorr_cnt_d = uncorr_cnt_q + 1'b1;
      end
    end
  end

  // Monitor state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        cnt_q[r] <= '0;
      end
      broken_q     <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      broken_q     <= broken_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  // Optional output stage; monitor state above always sees the unregistered vote.
  if (PIPE != 0) begin : g_pipe
    logic [2:0][DATA_W-1:0] voted_q;
    logic [2:0]             block_err_q;
    logic                   err_detected_q;
    logic                   err_corrected_q;
    logic                   uncorrectable_q;

    // Registered vote outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        voted_q         <= '0;
        block_err_q     <= '0;
        err_detected_q  <= 1'b0;
        err_corrected_q <= 1'b0;
        uncorrectable_q <= 1'b0;
      end else begin
        voted_q         <= voted_d;
        block_err_q     <= block_err_d;
        err_detected_q  <= err_detected_d;
        err_corrected_q <= err_corrected_d;
        uncorrectable_q <= uncorrectable_d;
      end
    end

    assign bus.voted_o         = voted_q;
    assign bus.block_err_o     = block_err_q;
    assign bus.err_detected_o  = err_detected_q;
    assign bus.err_corrected_o = err_corrected_q;
    assign bus.uncorrectable_o = uncorrectable_q;
  end else begin : g_comb
    assign bus.voted_o         = voted_d;
    assign bus.block_err_o     = block_err_d;
    assign bus.err_detected_o  = err_detected_d;
    assign bus.err_corrected_o = err_corrected_d;
    assign bus.uncorrectable_o = uncorrectable_d;
  end

  assign bus.is_broken_o  = broken_q;
  assign bus.all_broken_o = &broken_q;
  assign bus.corr_cnt_o   = corr_cnt_q;
  assign bus.uncorr_cnt_o = uncorr_cnt_q;

endmodule

// File: tb/tb_cv32e40p_tmr_vote_monitor.sv
// Directed bench: a table of one-cycle vectors for the combinational DUT, plus
// hand-written sequences for the pipelined DUT and asynchronous reset.
module tb_cv32e40p_tmr_vote_monitor;

  logic clk = 1'b0;
  logic rst;
  logic rst_p;

  always #5 clk = ~clk;

  cv32e40p_tmr_vote_monitor_if #(.DATA_W(32), .EVT_W(16)) bus_c ();
  cv32e40p_tmr_vote_monitor_if #(.DATA_W(32), .EVT_W(16)) bus_p ();

  cv32e40p_tmr_vote_monitor #(.DATA_W(32), .TOUT(1), .PIPE(0)) u_dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
  );

  cv32e40p_tmr_vote_monitor #(.DATA_W(32), .TOUT(0), .PIPE(1)) u_dut_p (
    .clk (clk),
    .rst (rst_p),
    .bus (bus_p)
  );

  typedef struct {
    logic [31:0] v0, v1, v2;
    logic [2:0]  set, clr;
    logic        cclr;
    logic [31:0] ev;
    logic [2:0]  eb;
    logic        ed, ec, eu, ea;
    logic [2:0]  ebrk;
    int          ecc, euc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic [31:0] v0, v1, v2, input logic [2:0] set, clr,
                     input logic cclr, input logic [31:0] ev, input logic [2:0] eb,
                     input logic ed, ec, eu, ea, input logic [2:0] ebrk,
                     input int ecc, euc);
    vec_t t;
    t.v0 = v0; t.v1 = v1; t.v2 = v2; t.set = set; t.clr = clr; t.cclr = cclr;
    t.ev = ev; t.eb = eb; t.ed = ed; t.ec = ec; t.eu = eu; t.ea = ea;
    t.ebrk = ebrk; t.ecc = ecc; t.euc = euc;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_p = 1'b1;
    bus_c.to_vote_i = '0; bus_c.set_broken_i = '0; bus_c.clear_broken_i = '0;
    bus_c.cnt_clear_i = 1'b0;
    bus_p.to_vote_i = '0; bus_p.set_broken_i = '0; bus_p.clear_broken_i = '0;
    bus_p.cnt_clear_i = 1'b0;

    //   v0         v1         v2         set     clr     cc ev         eb      d  c  u  a  brk     cc ucc
    add(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 3'b000, 3'b000, 0, 32'hA5A5A5A5,
        3'b000, 0, 0, 0, 0, 3'b000, 0, 0);
    add(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b010, 1, 1, 0, 0, 3'b000, 1, 0);
    add(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b010, 1, 1, 0, 0, 3'b000, 2, 0);
    add(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b010, 1, 1, 0, 0, 3'b000, 3, 0);
    add(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b010, 1, 1, 0, 0, 3'b010, 4, 0);
    add(0, 32'hFFFFFFFF, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 3'b010, 4, 0);
    add(0, 0, 0, 3'b000, 3'b010, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 4, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 32'h10, 3'b000, 3'b000, 0, 0, 3'b100, 1, 1, 0, 0, 3'b000, 5 + i, 0);
    for (int i = 0; i < 6; i++)
      add(0, 0, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 7, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 32'h10, 3'b000, 3'b000, 0, 0, 3'b100, 1, 1, 0, 0,
          (i == 3) ? 3'b100 : 3'b000, 8 + i, 0);
    add(0, 0, 0, 3'b000, 3'b100, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 11, 0);
    add(0, 0, 0, 3'b001, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 3'b001, 11, 0);
    add(32'hDEAD, 32'h11, 32'h22, 3'b000, 3'b000, 0, 32'h11, 3'b000, 1, 0, 1, 0,
        3'b001, 11, 1);
    add(32'hDEAD, 32'h11, 32'h22, 3'b000, 3'b000, 0, 32'h11, 3'b000, 1, 0, 1, 0,
        3'b001, 11, 2);
    add(0, 32'h33, 32'h33, 3'b001, 3'b001, 0, 32'h33, 3'b000, 0, 0, 0, 0, 3'b001, 11, 2);
    add(32'h44, 32'h44, 32'h44, 3'b000, 3'b001, 0, 32'h44, 3'b000, 0, 0, 0, 0,
        3'b000, 11, 2);
    add(5, 6, 7, 3'b110, 3'b000, 0, 7, 3'b011, 1, 1, 0, 0, 3'b110, 12, 2);
    add(9, 10, 11, 3'b000, 3'b000, 0, 9, 3'b000, 0, 0, 0, 0, 3'b110, 12, 2);
    add(9, 10, 11, 3'b001, 3'b000, 0, 9, 3'b000, 0, 0, 0, 0, 3'b111, 12, 2);
    add(32'h77, 1, 2, 3'b000, 3'b000, 0, 32'h77, 3'b000, 0, 0, 0, 1, 3'b111, 12, 2);
    add(32'h77, 1, 2, 3'b000, 3'b000, 1, 32'h77, 3'b000, 0, 0, 0, 1, 3'b111, 0, 0);
    add(0, 0, 0, 3'b000, 3'b111, 0, 0, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0);
    add(32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 3'b000, 0, 32'hFFFF0000,
        3'b101, 1, 1, 0, 0, 3'b000, 1, 0);
    add(0, 1, 0, 3'b000, 3'b000, 1, 0, 3'b010, 1, 1, 0, 0, 3'b000, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rst_p = 1'b0;

    // Reset state
    check("rst is_broken", 128'(bus_c.is_broken_o), 128'(3'b000));
    check("rst corr_cnt", 128'(bus_c.corr_cnt_o), 128'(16'd0));
    check("rst uncorr_cnt", 128'(bus_c.uncorr_cnt_o), 128'(16'd0));
    check("rst pipe voted", 128'(bus_p.voted_o), 128'(96'd0));
    check("rst pipe flags", 128'({bus_p.block_err_o, bus_p.err_detected_o,
          bus_p.err_corrected_o, bus_p.uncorrectable_o}), 128'(6'd0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      bus_c.to_vote_i      = {tbl[i].v2, tbl[i].v1, tbl[i].v0};
      bus_c.set_broken_i   = tbl[i].set;
      bus_c.clear_broken_i = tbl[i].clr;
      bus_c.cnt_clear_i    = tbl[i].cclr;
      #4;
      check($sformatf("row%0d voted", i), 128'(bus_c.voted_o), 128'({3{tbl[i].ev}}));
      check($sformatf("row%0d block_err", i), 128'(bus_c.block_err_o), 128'(tbl[i].eb));
      check($sformatf("row%0d det/corr/unc/allb", i),
            128'({bus_c.err_detected_o, bus_c.err_corrected_o, bus_c.uncorrectable_o,
                  bus_c.all_broken_o}),
            128'({tbl[i].ed, tbl[i].ec, tbl[i].eu, tbl[i].ea}));
      @(posedge clk);
      #1;
      check($sformatf("row%0d is_broken", i), 128'(bus_c.is_broken_o), 128'(tbl[i].ebrk));
      check($sformatf("row%0d corr_cnt", i), 128'(bus_c.corr_cnt_o), 128'(16'(tbl[i].ecc)));
      check($sformatf("row%0d uncorr_cnt", i), 128'(bus_c.uncorr_cnt_o),
            128'(16'(tbl[i].euc)));
    end
    bus_c.to_vote_i = '0; bus_c.set_broken_i = '0; bus_c.clear_broken_i = '0;
    bus_c.cnt_clear_i = 1'b0;

    // Pipelined DUT: clean cycle appears one edge later
    bus_p.to_vote_i = {3{32'h55}};
    #4;
    check("pipe voted before edge", 128'(bus_p.voted_o), 128'(96'd0));
    @(posedge clk);
    #1;
    check("pipe voted clean", 128'(bus_p.voted_o), 128'({3{32'h55}}));
    check("pipe block_err clean", 128'(bus_p.block_err_o), 128'(3'b000));

    // Fault at cycle N, visible at N+1; forced break is not delayed
    bus_p.to_vote_i    = {32'h55, 32'h54, 32'h55};
    bus_p.set_broken_i = 3'b100;
    #4;
    check("pipe block_err at N", 128'(bus_p.block_err_o), 128'(3'b000));
    check("pipe corr at N", 128'(bus_p.err_corrected_o), 128'(1'b0));
    @(posedge clk);
    #1;
    bus_p.set_broken_i = 3'b000;
    check("pipe block_err at N+1", 128'(bus_p.block_err_o), 128'(3'b010));
    check("pipe det/corr/unc at N+1", 128'({bus_p.err_detected_o, bus_p.err_corrected_o,
          bus_p.uncorrectable_o}), 128'(3'b110));
    check("pipe voted at N+1", 128'(bus_p.voted_o), 128'({3{32'h55}}));
    check("pipe is_broken", 128'(bus_p.is_broken_o), 128'(3'b100));
    check("pipe corr_cnt", 128'(bus_p.corr_cnt_o), 128'(16'd1));

    // Asynchronous reset mid-cycle clears everything before the next edge
    #2;
    rst_p = 1'b1;
    #1;
    check("async rst voted", 128'(bus_p.voted_o), 128'(96'd0));
    check("async rst flags", 128'({bus_p.block_err_o, bus_p.err_detected_o,
          bus_p.err_corrected_o, bus_p.uncorrectable_o}), 128'(6'd0));
    check("async rst is_broken", 128'(bus_p.is_broken_o), 128'(3'b000));
    check("async rst corr_cnt", 128'(bus_p.corr_cnt_o), 128'(16'd0));
    @(negedge clk);
    rst_p = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_vote_monitor.md
Name: cv32e40p_tmr_vote_monitor

Overview:
- Generic TMR voting and breakage-monitoring unit for any triplicated replica group, e.g. an FSM, decoder or datapath slice.
- Votes a DATA_W-bit output bundle across three replicas, attributes each mismatch to the disagreeing replica, and tracks replica health with leaky saturating counters.
- Excludes broken replicas from the vote, supports software repair, and keeps event statistics.
- Successor to the fixed-width per-stage voter/monitor wrappers: width, output triplication, pipelining and repair are all configurable.

Parameters:
- DATA_W, 32: width of one replica's output bundle.
- TOUT, 1: 1 = three independent voters, one per voted_o lane; 0 = one voter fanned out to all three lanes.
- PIPE, 0: 0 = combinational vote path; 1 = vote outputs registered, one-cycle latency.
- COUNT_BIT, 4: width of each health counter.
- INCREMENT, 2: amount added to a health counter per erroneous cycle.
- DECREMENT, 1: amount subtracted from a health counter per clean cycle.
- BREAKING_THRESHOLD, 8: counter value at or above which a replica is declared broken.
- EVT_W, 16: width of the saturating event counters.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- to_vote_i, input, 3xDATA_W: replica outputs; index r = replica r.
- voted_o, output, 3xDATA_W: voted result; all three lanes carry the same value.
- block_err_o, output, 3: replica r disagreed with the vote this cycle.
- err_detected_o, output, 1: any disagreement among the healthy replicas.
- err_corrected_o, output, 1: a disagreement occurred and was masked.
- uncorrectable_o, output, 1: a disagreement occurred that could not be resolved.
- set_broken_i, input, 3: force replica r broken.
- clear_broken_i, input, 3: repair replica r; clears its broken flag and counter.
- is_broken_o, output, 3: per-replica broken flag.
- all_broken_o, output, 1: all three replicas are broken.
- cnt_clear_i, input, 1: clear both event counters.
- corr_cnt_o, output, EVT_W: number of cycles with err_corrected.
- uncorr_cnt_o, output, EVT_W: number of cycles with uncorrectable.

Behaviour:
- Reset: all health counters = 0, is_broken_o = 0, event counters = 0. With PIPE=1, voted_o, block_err_o and all error flags reset to 0.
- H is the number of healthy replicas (is_broken_o[r]=0). Vote by H:
  - H=3: bitwise majority. block_err[r] = (replica r != voted). err_detected = err_corrected = OR of block_err. uncorrectable = 0.
  - H=2: voted = lowest-index healthy replica. If the two healthy replicas differ: err_detected=1, uncorrectable=1, err_corrected=0, block_err=0 (fault cannot be attributed).
  - H=1: voted = the healthy replica; no detection is possible; all error flags = 0.
  - H=0: voted = replica 0; all_broken_o=1; all error flags = 0.
- Broken replicas never assert block_err, whatever their data.
- Health counter r, updated each clock:
  - if clear_broken_i[r]: counter = 0;
  - else if broken: hold;
  - else if block_err[r]: counter + INCREMENT, saturating at 2^COUNT_BIT-1;
  - else: counter - DECREMENT, floored at 0.
- is_broken_o[r]:
  - set on the next edge when set_broken_i[r]=1, or when the updated counter >= BREAKING_THRESHOLD;
  - cleared on the next edge by clear_broken_i[r];
  - set_broken_i wins over clear_broken_i on the same cycle; the counter still clears.
- Breakage is sticky until cleared. It takes effect on the vote in the cycle after the flag registers.
- Event counters:
  - each increments by 1 per cycle in which its flag is set (flag sampled pre-pipeline), saturating at 2^EVT_W-1;
  - cnt_clear_i zeroes both counters and has priority over an increment in the same cycle.
- PIPE=1: voted_o, block_err_o, err_detected_o, err_corrected_o and uncorrectable_o are the registered versions of the combinational values, one cycle late. Health and event counters always use the combinational values. is_broken_o is never delayed.
- TOUT: changes redundancy only. Functional outputs are identical for TOUT=0 and TOUT=1.
- Reset asserted mid-operation: immediately clears all state, including sticky broken flags.

Test Plan:
- Clean vote, PIPE=0: all replicas 0xA5A5A5A5 → voted 0xA5A5A5A5; all flags 0; counters stay 0.
- Single replica fault: replica 1 = 0x00000001, others 0 → voted 0; block_err=3'b010; err_corrected=1. After 4 consecutive cycles is_broken_o=3'b010 (counter 2,4,6,8 ≥ 8); corr_cnt_o=4 after those 4 cycles.
- Leaky decay: replica 2 faulty for 3 cycles, then clean for 6 cycles → counter goes 6, then 0; no break.
- Degraded mode: replica 0 broken via set_broken_i; replicas 1 and 2 differ → voted = replica 1; uncorrectable=1; block_err=0; uncorr_cnt_o increments.
- Repair: clear_broken_i[0] pulsed for 1 cycle → is_broken_o[0]=0 and counter 0 on the next edge. set+clear on the same cycle → broken stays 1.
- PIPE=1 latency and reset: fault injected at cycle N → block_err_o visible at N+1; rst asserted asynchronously → all outputs 0 before the next clock edge.
